// File: rtl/qbert_jump_if.sv
// Q*bert move interface: command handshake, mover coordinates and landing/fall status.
// The controller takes the master modport; the command source and mover share the slave side.
interface qbert_jump_if;
    logic        cmd_valid;
    logic [1:0]  cmd_dir;
    logic        cmd_ready;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;
    logic [10:0] x0;
    logic [10:0] x1;
    logic [9:0]  y0;
    logic [9:0]  y1;
    logic        jump;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        landed;
    logic        fell;
    logic        timeout;

    modport master (
        input  cmd_valid, cmd_dir, qbert_x, qbert_y,
        output cmd_ready, x0, x1, y0, y1, jump, row, col, landed, fell, timeout
    );

    modport slave (
        output cmd_valid, cmd_dir, qbert_x, qbert_y,
        input  cmd_ready, x0, x1, y0, y1, jump, row, col, landed, fell, timeout
    );
endinterface

// File: rtl/qbert_jump_ctrl.sv
// Q*bert hop controller: turns direction commands into mover start/target coordinates,
// tracks the current cube, and reports landings, forced landings and falls.
module qbert_jump_ctrl #(
    parameter int unsigned ROWS    = 7,
    parameter logic [10:0] X_ORG   = 11'd100,
    parameter logic [9:0]  Y_ORG   = 10'd400,
    parameter logic [10:0] X_STEP  = 11'd60,
    parameter logic [9:0]  Y_HALF  = 10'd50,
    parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
    input logic          clk,
    input logic          reset,
    qbert_jump_if.master bus
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StCalc = 3'd1;
    localparam logic [2:0] StJump = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StLand = 3'd4;
    localparam logic [2:0] StFall = 3'd5;

    localparam logic [3:0] RowsW = 4'(ROWS);

    logic [2:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [2:0]  row_q, row_d, col_q, col_d;
    logic [2:0]  tr_q, tr_d, tc_q, tc_d;
    logic [10:0] x0_q, x0_d, x1_q, x1_d;
    logic [9:0]  y0_q, y0_d, y1_q, y1_d;
    logic        jump_q, jump_d;
    logic        landed_q, landed_d;
    logic        fell_q, fell_d;
    logic        timeout_q, timeout_d;
    logic        ready_q, ready_d;
    logic [23:0] cnt_q, cnt_d;

    logic [3:0]  tr, tc;
    logic        under;
    logic        tgt_ok;
    logic        arrive;

    function automatic logic [10:0] cube_x(input logic [2:0] r);
        logic [11:0] v;
        v = 12'(X_ORG) + 12'(r) * 12'(X_STEP);
        return v[10:0];
    endfunction

    function automatic logic [9:0] cube_y(input logic [2:0] r, input logic [2:0] c);
        logic [11:0] v;
        v = 12'(Y_ORG) - 12'(r) * 12'(Y_HALF) + 12'(c) * 12'(Y_HALF) * 12'd2;
        return v[9:0];
    endfunction

    // Target cube; under flags a step off the top or left edge before wraparound.
    always_comb begin
        tr    = {1'b0, row_q};
        tc    = {1'b0, col_q};
        under = 1'b0;
        unique case (dir_q)
            2'b00: tr = tr + 4'd1;
            2'b01: begin
                tr = tr + 4'd1;
                tc = tc + 4'd1;
            end
            2'b10: begin
                under = (row_q == 3'd0) || (col_q == 3'd0);
                tr    = tr - 4'd1;
                tc    = tc - 4'd1;
            end
            2'b11: begin
                under = (row_q == 3'd0);
                tr    = tr - 4'd1;
            end
        endcase
        tgt_ok = !under && (tr < RowsW) && (tc <= tr);
    end

    assign arrive = (bus.qbert_x == x1_q) && (bus.qbert_y == y1_q);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        row_d     = row_q;
        col_d     = col_q;
        tr_d      = tr_q;
        tc_d      = tc_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        cnt_d     = cnt_q;
        jump_d    = 1'b0;
        landed_d  = 1'b0;
        fell_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    dir_d   = bus.cmd_dir;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (tgt_ok) begin
                    x0_d    = cube_x(row_q);
                    y0_d    = cube_y(row_q, col_q);
                    x1_d    = cube_x(tr[2:0]);
                    y1_d    = cube_y(tr[2:0], tc[2:0]);
                    tr_d    = tr[2:0];
                    tc_d    = tc[2:0];
                    jump_d  = 1'b1;
                    state_d = StJump;
                end else begin
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    x0_d    = X_ORG;
                    x1_d    = X_ORG;
                    y0_d    = Y_ORG;
                    y1_d    = Y_ORG;
                    fell_d  = 1'b1;
                    state_d = StFall;
                end
            end
            StJump: begin
                cnt_d   = 24'd0;
                state_d = StWait;
            end
            StWait: begin
                // Arrival takes priority over an expiring counter.
                if (arrive || (cnt_q == TIMEOUT - 24'd1)) begin
                    row_d     = tr_q;
                    col_d     = tc_q;
                    landed_d  = 1'b1;
                    timeout_d = !arrive;
                    state_d   = StLand;
                end else begin
                    cnt_d = cnt_q + 24'd1;
                end
            end
            StLand:  state_d = StIdle;
            StFall:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            dir_q     <= 2'b00;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            tr_q      <= 3'd0;
            tc_q      <= 3'd0;
            x0_q      <= X_ORG;
            x1_q      <= X_ORG;
            y0_q      <= Y_ORG;
            y1_q      <= Y_ORG;
            cnt_q     <= 24'd0;
            jump_q    <= 1'b0;
            landed_q  <= 1'b0;
            fell_q    <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tr_q      <= tr_d;
            tc_q      <= tc_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            cnt_q     <= cnt_d;
            jump_q    <= jump_d;
            landed_q  <= landed_d;
            fell_q    <= fell_d;
            timeout_q <= timeout_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.x0        = x0_q;
    assign bus.x1        = x1_q;
    assign bus.y0        = y0_q;
    assign bus.y1        = y1_q;
    assign bus.jump      = jump_q;
    assign bus.row       = row_q;
    assign bus.col       = col_q;
    assign bus.landed    = landed_q;
    assign bus.fell      = fell_q;
    assign bus.timeout   = timeout_q;

endmodule
